// File: rtl/adder_multicycle_pkg.sv
// Shared constants and helpers for adder_multicycle.
package adder_multicycle_pkg;

`ifndef ADDER_DEFS_SV
`include "adder_defs.sv"
`endif

    localparam logic [1:0] ST_IDLE = `ADDER_ST_IDLE;
    localparam logic [1:0] ST_RUN  = `ADDER_ST_RUN;
    localparam logic [1:0] ST_DONE = `ADDER_ST_DONE;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_defs.sv
// State encodings shared by the multicycle arithmetic blocks.
// Guarded so it can be compiled on its own or pulled in by any package.
`ifndef ADDER_DEFS_SV
`define ADDER_DEFS_SV

`define ADDER_ST_IDLE 2'd0
`define ADDER_ST_RUN  2'd1
`define ADDER_ST_DONE 2'd2

`endif

// File: rtl/adder_multicycle_nbits.sv
// Bit-serial building blocks: a full adder and an N-bit ripple chain of them.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_nbits
    import adder_multicycle_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    // Each stage owns its carry nets so the chain is not a self-referencing vector.
    for (genvar i = 0; i < N; i++) begin : g_bit
        logic ci_s;
        logic co_s;
        if (i == 0) begin : g_first
            assign ci_s = cin;
        end else begin : g_rest
            assign ci_s = g_bit[i-1].co_s;
        end
        fulladder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (ci_s),
            .s    (s[i]),
            .cout (co_s)
        );
    end

    assign cout = g_bit[N-1].co_s;
endmodule

// File: rtl/adder_multicycle.sv
// Multicycle adder/subtractor: processes CHUNK bits per cycle, LSB chunk first,
// with valid/ready handshakes on both the operand and the result side.
module adder_multicycle
    import adder_multicycle_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_w_clk,
    input  logic             i_w_rst_n,
    input  logic             i_w_valid,
    output logic             o_w_ready,
    input  logic [WIDTH-1:0] i_w_a,
    input  logic [WIDTH-1:0] i_w_b,
    input  logic             i_w_cin,
    input  logic             i_w_sub,
    output logic             o_w_valid,
    input  logic             i_w_ready,
    output logic [WIDTH-1:0] o_w_s,
    output logic             o_w_cout,
    output logic             o_w_ovf
);
    localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCHUNK     = WIDTH / SAFE_CHUNK;
    localparam int CW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]    LAST_CHUNK = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({SAFE_CHUNK{1'b1}});

    if ((CHUNK < 1) || ((WIDTH % SAFE_CHUNK) != 0) || (WIDTH < 2)) begin : g_param_check
        $error("adder_multicycle: CHUNK must be >= 1 and divide WIDTH (WIDTH >= 2)");
    end

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             ovf_r;

    logic [31:0]      base_s;
    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK-1:0] sum_s;
    logic             chunk_cout_s;
    logic [WIDTH-1:0] s_next_s;
    logic             last_s;

    // Select the active chunk by shifting rather than indexing, so the
    // datapath stays a plain barrel shift for any CHUNK/WIDTH pairing.
    assign base_s    = 32'(cnt_r) * 32'(SAFE_CHUNK);
    assign a_chunk_s = CHUNK'(a_r >> base_s);
    assign b_chunk_s = CHUNK'(b_r >> base_s);
    assign last_s    = (cnt_r == LAST_CHUNK);

    adder_nbits #(.N(CHUNK)) u_chunk_add (
        .a    (a_chunk_s),
        .b    (b_chunk_s),
        .cin  (carry_r),
        .s    (sum_s),
        .cout (chunk_cout_s)
    );

    // Merge the freshly computed chunk into the result word at its slot.
    always_comb begin
        s_next_s = s_r;
        if (state_r == ST_RUN) begin
            s_next_s = (s_r & ~(CHUNK_MASK << base_s)) | (WIDTH'(sum_s) << base_s);
        end else begin
            s_next_s = s_r;
        end
    end

    // Control FSM, operand capture and per-chunk result accumulation.
    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            s_r     <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_w_valid) begin
                        // Subtraction is A + ~B + 1; the caller's carry-in is ignored.
                        a_r     <= i_w_a;
                        b_r     <= i_w_sub ? ~i_w_b : i_w_b;
                        carry_r <= i_w_sub | i_w_cin;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    s_r     <= s_next_s;
                    carry_r <= chunk_cout_s;
                    if (last_s) begin
                        cout_r  <= chunk_cout_s;
                        ovf_r   <= signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1], sum_s[CHUNK-1]);
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (i_w_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_w_ready = (state_r == ST_IDLE);
    assign o_w_valid = (state_r == ST_DONE);
    assign o_w_s     = s_r;
    assign o_w_cout  = cout_r;
    assign o_w_ovf   = ovf_r;

endmodule

// File: tb/tb_adder_multicycle.sv
// Directed and randomised checks of adder_multicycle in three configurations.
`timescale 1ns/1ps
module tb_adder_multicycle;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  vld   = 3'b000;
    logic [2:0]  rdyc  = 3'b000;
    logic [31:0] a_in  = 32'd0;
    logic [31:0] b_in  = 32'd0;
    logic        cin_in = 1'b0;
    logic        sub_in = 1'b0;
    wire  [2:0]  ordy, oval, ocout, oovf;
    wire  [7:0]  s0, s1;
    wire  [31:0] s2;
    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    adder_multicycle #(.WIDTH(8), .CHUNK(4)) u_dut84 (
        .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_valid(vld[0]), .o_w_ready(ordy[0]),
        .i_w_a(a_in[7:0]), .i_w_b(b_in[7:0]), .i_w_cin(cin_in), .i_w_sub(sub_in),
        .o_w_valid(oval[0]), .i_w_ready(rdyc[0]), .o_w_s(s0), .o_w_cout(ocout[0]), .o_w_ovf(oovf[0]));

    adder_multicycle #(.WIDTH(8), .CHUNK(8)) u_dut88 (
        .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_valid(vld[1]), .o_w_ready(ordy[1]),
        .i_w_a(a_in[7:0]), .i_w_b(b_in[7:0]), .i_w_cin(cin_in), .i_w_sub(sub_in),
        .o_w_valid(oval[1]), .i_w_ready(rdyc[1]), .o_w_s(s1), .o_w_cout(ocout[1]), .o_w_ovf(oovf[1]));

    adder_multicycle #(.WIDTH(32), .CHUNK(8)) u_dut328 (
        .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_valid(vld[2]), .o_w_ready(ordy[2]),
        .i_w_a(a_in), .i_w_b(b_in), .i_w_cin(cin_in), .i_w_sub(sub_in),
        .o_w_valid(oval[2]), .i_w_ready(rdyc[2]), .o_w_s(s2), .o_w_cout(ocout[2]), .o_w_ovf(oovf[2]));

    function automatic logic [31:0] get_s(input int idx);
        case (idx)
            0:       return {24'd0, s0};
            1:       return {24'd0, s1};
            default: return s2;
        endcase
    endfunction

    function automatic int lat_of(input int idx);
        case (idx)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    // Reference: {cout, ovf, sum} from plain wide arithmetic.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] mask, bp, s;
        logic [32:0] full;
        logic        ci, c, ov;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        bp   = (sub ? ~b : b) & mask;
        ci   = sub ? 1'b1 : cin;
        full = {1'b0, a & mask} + {1'b0, bp} + {32'd0, ci};
        s    = full[31:0] & mask;
        c    = full[w];
        ov   = (a[w-1] == bp[w-1]) && (s[w-1] != a[w-1]);
        return {c, ov, s};
    endfunction

    task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic [31:0] es,
                         input logic ec, input logic eo, input bit scramble,
                         input int stall, input string name);
        int lat;
        compared++;
        if (ordy[idx] !== 1'b1) begin
            mismatched++; $display("FAIL %s idle_ready: got %b want 1", name, ordy[idx]);
        end
        a_in = a; b_in = b; cin_in = cin; sub_in = sub;
        vld[idx] = 1'b1; rdyc[idx] = 1'b0;
        @(posedge clk); #1;
        vld[idx] = 1'b0;
        compared++;
        if (ordy[idx] !== 1'b0) begin
            mismatched++; $display("FAIL %s busy_ready: got %b want 0", name, ordy[idx]);
        end
        if (scramble) begin
            a_in = ~a; b_in = 32'h5A5A_A5A5; cin_in = ~cin; sub_in = ~sub;
        end
        lat = 0;
        while ((oval[idx] !== 1'b1) && (lat < 40)) begin
            @(posedge clk); #1; lat++;
        end
        compared++;
        if (lat != lat_of(idx)) begin
            mismatched++; $display("FAIL %s latency: got %0d want %0d", name, lat, lat_of(idx));
        end
        compared++;
        if (get_s(idx) !== es) begin
            mismatched++; $display("FAIL %s sum: got %h want %h", name, get_s(idx), es);
        end
        compared++;
        if (ocout[idx] !== ec) begin
            mismatched++; $display("FAIL %s cout: got %b want %b", name, ocout[idx], ec);
        end
        compared++;
        if (oovf[idx] !== eo) begin
            mismatched++; $display("FAIL %s ovf: got %b want %b", name, oovf[idx], eo);
        end
        repeat (stall) begin
            @(posedge clk); #1;
        end
        if (stall > 0) begin
            compared++;
            if ((oval[idx] !== 1'b1) || (get_s(idx) !== es)) begin
                mismatched++; $display("FAIL %s stall_hold: got valid %b sum %h want 1 %h", name, oval[idx], get_s(idx), es);
            end
        end
        rdyc[idx] = 1'b1;
        @(posedge clk); #1;
        rdyc[idx] = 1'b0;
        compared++;
        if ((oval[idx] !== 1'b0) || (ordy[idx] !== 1'b1)) begin
            mismatched++; $display("FAIL %s release: got valid %b ready %b want 0 1", name, oval[idx], ordy[idx]);
        end
        compared++;
        if (get_s(idx) !== es) begin
            mismatched++; $display("FAIL %s idle_hold: got %h want %h", name, get_s(idx), es);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        compared++;
        if ((ordy !== 3'b111) || (oval !== 3'b000) || (ocout !== 3'b000) || (oovf !== 3'b000)) begin
            mismatched++; $display("FAIL reset_flags: got rdy %b val %b cout %b ovf %b want 111 000 000 000", ordy, oval, ocout, oovf);
        end
        compared++;
        if ((s0 !== 8'h00) || (s1 !== 8'h00) || (s2 !== 32'h0)) begin
            mismatched++; $display("FAIL reset_sum: got %h %h %h want 0", s0, s1, s2);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_directed();
        do_op(0, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0, 0, "add_7f_01");
        do_op(0, 32'hFF, 32'hFF, 1'b1, 1'b0, 32'hFF, 1'b1, 1'b0, 1'b0, 0, "add_ff_ff_c");
        do_op(0, 32'h00, 32'h01, 1'b0, 1'b1, 32'hFF, 1'b0, 1'b0, 1'b0, 1, "sub_00_01");
        do_op(0, 32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b1, 1'b1, 1'b1, 0, "sub_80_01_scr");
        do_op(0, 32'h12, 32'h34, 1'b1, 1'b0, 32'h47, 1'b0, 1'b0, 1'b0, 2, "add_12_34_c");
        do_op(0, 32'h05, 32'h05, 1'b1, 1'b1, 32'h00, 1'b1, 1'b0, 1'b0, 0, "sub_05_05");
        do_op(1, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0, 0, "w8c8_add");
        do_op(1, 32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b1, 1'b1, 1'b1, 1, "w8c8_sub");
        do_op(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 0, "w32_wrap");
        do_op(2, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 0, "w32_sub");
        do_op(2, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 3, "w32_carry");
    endtask

    task automatic test_stall();
        a_in = 32'h3C; b_in = 32'h0F; cin_in = 1'b0; sub_in = 1'b0;
        vld[0] = 1'b1; rdyc[0] = 1'b0;
        @(posedge clk); #1;
        a_in = 32'h01; b_in = 32'h02;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            compared++;
            if ((oval[0] !== 1'b1) || (ordy[0] !== 1'b0) || (s0 !== 8'h4B) || (ocout[0] !== 1'b0) || (oovf[0] !== 1'b0)) begin
                mismatched++;
                $display("FAIL stall_%0d: got val %b rdy %b s %h c %b o %b want 1 0 4b 0 0", i, oval[0], ordy[0], s0, ocout[0], oovf[0]);
            end
            @(posedge clk); #1;
        end
        rdyc[0] = 1'b1;
        @(posedge clk); #1;
        rdyc[0] = 1'b0;
        compared++;
        if ((ordy[0] !== 1'b1) || (oval[0] !== 1'b0) || (s0 !== 8'h4B)) begin
            mismatched++; $display("FAIL stall_release: got rdy %b val %b s %h want 1 0 4b", ordy[0], oval[0], s0);
        end
        @(posedge clk); #1;
        vld[0] = 1'b0;
        compared++;
        if (ordy[0] !== 1'b0) begin
            mismatched++; $display("FAIL stall_next_accept: got rdy %b want 0", ordy[0]);
        end
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ((oval[0] !== 1'b1) || (s0 !== 8'h03)) begin
            mismatched++; $display("FAIL stall_next_result: got val %b s %h want 1 03", oval[0], s0);
        end
        rdyc[0] = 1'b1;
        @(posedge clk); #1;
        rdyc[0] = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        a_in = 32'h11; b_in = 32'h22; cin_in = 1'b0; sub_in = 1'b0;
        vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ((ordy[0] !== 1'b1) || (oval[0] !== 1'b0) || (s0 !== 8'h00) || (ocout[0] !== 1'b0) || (oovf[0] !== 1'b0)) begin
            mismatched++;
            $display("FAIL midrun_reset: got rdy %b val %b s %h c %b o %b want 1 0 00 0 0", ordy[0], oval[0], s0, ocout[0], oovf[0]);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            compared++;
            if ((oval[0] !== 1'b0) || (s0 !== 8'h00)) begin
                mismatched++; $display("FAIL midrun_hold_%0d: got val %b s %h want 0 00", i, oval[0], s0);
            end
        end
        #2 rst_n = 1'b1;
        do_op(0, 32'h9C, 32'h64, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [33:0] exp;
        logic [31:0] a, b;
        logic        cin, sub;
        int          w;
        for (int idx = 0; idx < 3; idx++) begin
            w = (idx == 2) ? 32 : 8;
            for (int n = 0; n < 8; n++) begin
                a   = $urandom;
                b   = $urandom;
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
                if (w == 8) begin
                    a = a & 32'hFF;
                    b = b & 32'hFF;
                end
                exp = model(w, a, b, cin, sub);
                do_op(idx, a, b, cin, sub, exp[31:0], exp[33], exp[32], 1'b0,
                      $urandom_range(0, 3), $sformatf("rand_%0d_%0d", idx, n));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
